ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch unit for the in-order RV64 core. It sits between the PC register and decode. It takes the current PC, issues one instruction-memory read per PC over a valid/ready request channel, and presents the returned 32-bit instruction to decode with a valid/ready handshake. It drives the PC register's `bubble` input so the PC advances only when decode accepts an instruction, and it discards in-flight fetches when the PC is redirected by a branch or exception.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: PC value the unit expects after reset. Used only for the `inst_pc` reset value.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_in`  in  64  current PC from the PC register output.
- `redirect`  in  1  asserted in the cycle the PC register loads a non-sequential value (relative branch, absolute branch or exception).
- `bubble`  out  1  to the PC register. 1 means hold the PC.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_addr`  out  64  read address, equal to `pc_in`.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_resp_valid`  in  1  read data valid. Exactly one response per accepted request, in order, at least 1 cycle after acceptance.
- `imem_resp_data`  in  32  instruction word.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts the instruction.
- `inst_out`  out  32  instruction word.
- `inst_pc`  out  64  PC of `inst_out`.
- `inst_fault`  out  1  instruction-address-misaligned fault. Valid with `inst_valid`.

## Operation
- The FSM has four states: REQ, WAIT, KILL and VALID. The reset state is REQ.
- **REQ**
  - If `pc_in[1:0]` != 0: do not issue a request. Capture `inst_pc`=`pc_in`, `inst_out`=32'h0000_0013, `inst_fault`=1, and go to VALID.
  - Otherwise: `imem_req_valid`=1. On `imem_req_ready`, capture `inst_pc`=`pc_in` and go to WAIT. If `redirect` is also 1 in that cycle, go to KILL instead.
  - With `redirect` and no acceptance: stay in REQ. The new `pc_in` is used from the next cycle.
- **WAIT**
  - On `imem_resp_valid`: capture `inst_out`=`imem_resp_data`, `inst_fault`=0, and go to VALID.
  - If `redirect`=1 while waiting and no response arrives that cycle: go to KILL.
  - If `redirect`=1 in the same cycle as the response: drop the data and go to REQ.
- **KILL**: wait for the stale response, discard it, then go to REQ. No request is issued while in KILL.
- **VALID**
  - `inst_valid`=1. Outputs stay stable until accepted.
  - On `inst_ready`: go to REQ.
  - On `redirect` (with or without `inst_ready`): `inst_valid` is dropped from the next cycle. Go to REQ.
- **bubble**
  - `bubble`=0 only in VALID with `inst_ready`=1. Otherwise `bubble`=1.
  - The PC register gives branch and exception priority over bubble, so a redirect always moves the PC.
- At most one outstanding memory request.
- `inst_out`, `inst_pc` and `inst_fault` are registers. `imem_req_valid`, `inst_valid` and `bubble` are decoded from state and gated by `rst`.

## Timing
- **Reset values:** `imem_req_valid`=0, `inst_valid`=0, `bubble`=1 while `rst`=1. Registers reset to `inst_out`=0, `inst_pc`=`RESET_PC`, `inst_fault`=0, state REQ.
- The first request is issued in the first cycle after `rst` deasserts.
- **Minimum per-instruction cycle:**
  - Request accepted in cycle N, response in N+1, `inst_valid` in N+2.
  - Accepted in N+2 → PC increments at the end of N+2 → next request in N+3.
  - Throughput is 1 instruction per 3 cycles with zero-wait memory.
- Memory stalls extend REQ or WAIT. Decode stalls extend VALID. `bubble` stays 1 throughout.
- **Reset mid-operation:** return to REQ. A response that arrives for a request accepted before reset is ignored. The memory is reset on the same `rst`.
- **Misaligned PC:** fault is presented 1 cycle after entering REQ, with no memory traffic.

## Test plan
- **Reset release:** `rst` 1→0 with `pc_in`=0x8000_0000 and zero-wait memory.
  - Expect `imem_req_addr`=0x8000_0000 in the first cycle.
  - Expect `inst_valid` 2 cycles later with `inst_pc`=0x8000_0000 and the returned word.
- **Sequential stream:** memory returns 0x00100093, 0x00200113, 0x00300193; `inst_ready`=1.
  - Expect three instructions with `inst_pc` 0x8000_0000, 0x8000_0004, 0x8000_0008, 3 cycles apart.
  - `bubble`=0 only on the handshake cycles.
- **Stalls:** `imem_req_ready` low 2 cycles, response delayed 3 cycles, `inst_ready` low 2 cycles.
  - Expect exactly one request and one instruction.
  - Expect `bubble`=1 until the final handshake.
  - Outputs stay stable while `inst_ready`=0.
- **Redirect in WAIT:** request 0x8000_0010 accepted, `redirect` pulsed, `pc_in` becomes 0x8000_0100, response arrives 2 cycles later.
  - The stale word is never presented.
  - The next request address is 0x8000_0100.
- **Redirect coincident:** `redirect` in the same cycle as `imem_req_ready`, and separately in the same cycle as `imem_resp_valid`.
  - No stale instruction is presented.
  - The next `inst_pc` equals the redirected PC.
- **Misaligned:** `pc_in`=0x8000_0002.
  - Expect no `imem_req_valid`.
  - Expect `inst_valid` with `inst_fault`=1, `inst_out`=0x00000013, `inst_pc`=0x8000_0002.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// -----------------------------------------------------------------------------
// ifetch_unit_if
// Bundles the two handshake channels of the instruction fetch unit:
//   imem_req_*  : read request to instruction memory (valid/ready, 64-bit addr)
//   imem_resp_* : read response from instruction memory (valid, 32-bit word)
//   inst_*      : fetched instruction toward decode (valid/ready, word, PC,
//                 misaligned-fetch fault flag)
// Modports:
//   master : the fetch unit side
//   slave  : the memory/decode side (testbench or surrounding core)
// -----------------------------------------------------------------------------
interface ifetch_unit_if;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [63:0] inst_pc;
   logic        inst_fault;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data,
      output inst_valid,
      input  inst_ready,
      output inst_out,
      output inst_pc,
      output inst_fault
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data,
      input  inst_valid,
      output inst_ready,
      input  inst_out,
      input  inst_pc,
      input  inst_fault
   );
endinterface

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch unit for the in-order RV64 core. Issues one instruction
// memory read per PC, presents the returned word to decode, holds the PC
// register (o_bubble) until decode accepts, and discards fetches made stale
// by a PC redirect.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset
//   i_pc_in    : current PC from the PC register
//   i_redirect : PC register is loading a non-sequential value this cycle
//   o_bubble   : 1 = PC register holds its value
//   bus        : imem request/response and decode channels (master side)
// -----------------------------------------------------------------------------
module ifetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [63:0]   i_pc_in,
   input  logic          i_redirect,
   output logic          o_bubble,
   ifetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_KILL  = 2'd2,
      ST_VALID = 2'd3
   } state_t;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_inst_out;
   logic [63:0] r_inst_pc;
   logic        r_inst_fault;

   logic        w_misaligned;
   logic        w_load_pc;     // request accepted: remember its PC
   logic        w_load_resp;   // response kept: capture the word
   logic        w_load_fault;  // misaligned PC: synthesize a faulting NOP

   assign w_misaligned = (i_pc_in[1:0] != 2'b00);

   // Next-state and capture-enable decode.
   always_comb begin
      w_next_state = r_state;
      w_load_pc    = 1'b0;
      w_load_resp  = 1'b0;
      w_load_fault = 1'b0;
      case (r_state)
         ST_REQ: begin
            if (w_misaligned) begin
               // A redirect means pc_in is about to be replaced, so the
               // fault belongs to a PC that will never execute; wait for
               // the new PC instead.
               if (i_redirect) begin
                  w_next_state = ST_REQ;
               end else begin
                  w_load_fault = 1'b1;
                  w_next_state = ST_VALID;
               end
            end else if (bus.imem_req_ready) begin
               w_load_pc    = 1'b1;
               w_next_state = i_redirect ? ST_KILL : ST_WAIT;
            end else begin
               w_next_state = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (bus.imem_resp_valid) begin
               if (i_redirect) begin
                  w_next_state = ST_REQ;
               end else begin
                  w_load_resp  = 1'b1;
                  w_next_state = ST_VALID;
               end
            end else if (i_redirect) begin
               w_next_state = ST_KILL;
            end else begin
               w_next_state = ST_WAIT;
            end
         end
         ST_KILL: begin
            if (bus.imem_resp_valid) begin
               w_next_state = ST_REQ;
            end else begin
               w_next_state = ST_KILL;
            end
         end
         ST_VALID: begin
            if (bus.inst_ready || i_redirect) begin
               w_next_state = ST_REQ;
            end else begin
               w_next_state = ST_VALID;
            end
         end
         default: begin
            w_next_state = ST_REQ;
         end
      endcase
   end

   // State register and instruction output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_REQ;
         r_inst_out   <= 32'h0000_0000;
         r_inst_pc    <= RESET_PC;
         r_inst_fault <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_load_fault) begin
            r_inst_pc    <= i_pc_in;
            r_inst_out   <= NOP_WORD;
            r_inst_fault <= 1'b1;
         end else if (w_load_pc) begin
            r_inst_pc <= i_pc_in;
         end
         if (w_load_resp) begin
            r_inst_out   <= bus.imem_resp_data;
            r_inst_fault <= 1'b0;
         end
      end
   end

   // Handshake outputs are state decodes, forced inactive during reset.
   assign bus.imem_req_valid = ~i_rst & (r_state == ST_REQ) & ~w_misaligned;
   assign bus.imem_req_addr  = i_pc_in;
   assign bus.inst_valid     = ~i_rst & (r_state == ST_VALID);
   // The PC advances only on the decode handshake.
   assign o_bubble           = i_rst | ~((r_state == ST_VALID) & bus.inst_ready);

   assign bus.inst_out   = r_inst_out;
   assign bus.inst_pc    = r_inst_pc;
   assign bus.inst_fault = r_inst_fault;

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
// Directed bench for ifetch_unit. The bench plays the PC register (holds on
// bubble, loads the redirect target on redirect) and drives the memory and
// decode sides cycle by cycle. Inputs change 1 time unit after the rising
// edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;
   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [63:0] tgt;
   logic [63:0] pc;
   logic        bubble;
   int          n_total;
   int          n_pass;

   ifetch_unit_if bus ();

   ifetch_unit #(.RESET_PC(RESET_PC)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_pc_in    (pc),
      .i_redirect (redirect),
      .o_bubble   (bubble),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register model: redirect has priority over bubble.
   always @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= tgt;
      end else if (!bubble) begin
         pc <= pc + 64'd4;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Advance to just after the next rising edge and return all stimulus to idle.
   task automatic cyc();
      @(posedge clk);
      #1;
      redirect                = 1'b0;
      tgt                     = 64'h0;
      bus.imem_req_ready      = 1'b0;
      bus.imem_resp_valid     = 1'b0;
      bus.imem_resp_data      = 32'h0;
      bus.inst_ready          = 1'b0;
   endtask

   // One zero-wait fetch: request, response, decode handshake (3 cycles).
   task automatic fetch_zero_wait(input logic [63:0] exp_pc, input logic [31:0] word);
      cyc();
      rst = 1'b0;
      bus.imem_req_ready = 1'b1;
      #1;
      check_val("req_valid", {63'h0, bus.imem_req_valid}, 64'd1);
      check_val("req_addr", bus.imem_req_addr, exp_pc);
      check_val("inst_valid_req", {63'h0, bus.inst_valid}, 64'd0);
      check_val("bubble_req", {63'h0, bubble}, 64'd1);
      cyc();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = word;
      #1;
      check_val("req_valid_wait", {63'h0, bus.imem_req_valid}, 64'd0);
      check_val("inst_valid_wait", {63'h0, bus.inst_valid}, 64'd0);
      cyc();
      bus.inst_ready = 1'b1;
      #1;
      check_val("inst_valid", {63'h0, bus.inst_valid}, 64'd1);
      check_val("inst_pc", bus.inst_pc, exp_pc);
      check_val("inst_out", {32'h0, bus.inst_out}, {32'h0, word});
      check_val("inst_fault", {63'h0, bus.inst_fault}, 64'd0);
      check_val("bubble_hs", {63'h0, bubble}, 64'd0);
   endtask

   initial begin
      n_total             = 0;
      n_pass              = 0;
      rst                 = 1'b1;
      redirect            = 1'b0;
      tgt                 = 64'h0;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.inst_ready      = 1'b0;

      // Reset state.
      cyc();
      cyc();
      #1;
      check_val("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'd0);
      check_val("rst_inst_valid", {63'h0, bus.inst_valid}, 64'd0);
      check_val("rst_bubble", {63'h0, bubble}, 64'd1);
      check_val("rst_inst_out", {32'h0, bus.inst_out}, 64'd0);
      check_val("rst_inst_pc", bus.inst_pc, RESET_PC);
      check_val("rst_inst_fault", {63'h0, bus.inst_fault}, 64'd0);

      // Reset release and sequential stream, 3 cycles per instruction.
      fetch_zero_wait(64'h8000_0000, 32'h0010_0093);
      fetch_zero_wait(64'h8000_0004, 32'h0020_0113);
      fetch_zero_wait(64'h8000_0008, 32'h0030_0193);

      // Stalls: request not ready for 2 cycles.
      for (int i = 0; i < 2; i++) begin
         cyc();
         #1;
         check_val("stall_req_valid", {63'h0, bus.imem_req_valid}, 64'd1);
         check_val("stall_req_addr", bus.imem_req_addr, 64'h8000_000C);
         check_val("stall_bubble", {63'h0, bubble}, 64'd1);
      end
      cyc();
      bus.imem_req_ready = 1'b1;
      #1;
      check_val("stall_req_acc", {63'h0, bus.imem_req_valid}, 64'd1);
      // Response delayed 3 cycles: no second request, nothing presented.
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         check_val("stall_no_req", {63'h0, bus.imem_req_valid}, 64'd0);
         check_val("stall_no_inst", {63'h0, bus.inst_valid}, 64'd0);
         check_val("stall_bubble_w", {63'h0, bubble}, 64'd1);
      end
      cyc();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'h0040_0213;
      #1;
      // Decode stalls 2 cycles: outputs stable.
      for (int i = 0; i < 2; i++) begin
         cyc();
         #1;
         check_val("dstall_valid", {63'h0, bus.inst_valid}, 64'd1);
         check_val("dstall_out", {32'h0, bus.inst_out}, 64'h0040_0213);
         check_val("dstall_pc", bus.inst_pc, 64'h8000_000C);
         check_val("dstall_bubble", {63'h0, bubble}, 64'd1);
         check_val("dstall_no_req", {63'h0, bus.imem_req_valid}, 64'd0);
      end
      cyc();
      bus.inst_ready = 1'b1;
      #1;
      check_val("stall_hs_valid", {63'h0, bus.inst_valid}, 64'd1);
      check_val("stall_hs_bubble", {63'h0, bubble}, 64'd0);

      // Redirect while waiting for a response.
      cyc();
      bus.imem_req_ready = 1'b1;
      #1;
      check_val("rdw_req_addr", bus.imem_req_addr, 64'h8000_0010);
      cyc();
      redirect = 1'b1;
      tgt      = 64'h8000_0100;
      #1;
      check_val("rdw_inst_valid0", {63'h0, bus.inst_valid}, 64'd0);
      cyc();
      #1;
      check_val("rdw_kill_noreq", {63'h0, bus.imem_req_valid}, 64'd0);
      cyc();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hDEAD_BEEF;
      #1;
      check_val("rdw_kill_noreq2", {63'h0, bus.imem_req_valid}, 64'd0);
      check_val("rdw_inst_valid1", {63'h0, bus.inst_valid}, 64'd0);
      fetch_zero_wait(64'h8000_0100, 32'h0050_0293);

      // Redirect coincident with request acceptance.
      cyc();
      bus.imem_req_ready = 1'b1;
      redirect           = 1'b1;
      tgt                = 64'h8000_0200;
      #1;
      check_val("rdq_req_addr", bus.imem_req_addr, 64'h8000_0104);
      cyc();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hBAD0_0001;
      #1;
      check_val("rdq_kill_noreq", {63'h0, bus.imem_req_valid}, 64'd0);
      check_val("rdq_inst_valid", {63'h0, bus.inst_valid}, 64'd0);
      fetch_zero_wait(64'h8000_0200, 32'h0060_0313);

      // Redirect coincident with the response.
      cyc();
      bus.imem_req_ready = 1'b1;
      #1;
      check_val("rdr_req_addr", bus.imem_req_addr, 64'h8000_0204);
      cyc();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hBAD0_0002;
      redirect            = 1'b1;
      tgt                 = 64'h8000_0300;
      #1;
      check_val("rdr_inst_valid", {63'h0, bus.inst_valid}, 64'd0);
      fetch_zero_wait(64'h8000_0300, 32'h0070_0393);

      // Misaligned PC: redirect to 0x8000_0002 while idling in REQ.
      cyc();
      redirect = 1'b1;
      tgt      = 64'h8000_0002;
      #1;
      check_val("mis_pre_addr", bus.imem_req_addr, 64'h8000_0304);
      cyc();
      bus.imem_req_ready = 1'b1;
      #1;
      check_val("mis_no_req", {63'h0, bus.imem_req_valid}, 64'd0);
      check_val("mis_inst_valid0", {63'h0, bus.inst_valid}, 64'd0);
      cyc();
      #1;
      check_val("mis_inst_valid", {63'h0, bus.inst_valid}, 64'd1);
      check_val("mis_fault", {63'h0, bus.inst_fault}, 64'd1);
      check_val("mis_out", {32'h0, bus.inst_out}, 64'h0000_0013);
      check_val("mis_pc", bus.inst_pc, 64'h8000_0002);
      check_val("mis_no_req2", {63'h0, bus.imem_req_valid}, 64'd0);
      check_val("mis_bubble", {63'h0, bubble}, 64'd1);
      // Redirect out of VALID without a decode handshake.
      cyc();
      redirect = 1'b1;
      tgt      = 64'h8000_0400;
      #1;
      check_val("vrd_bubble", {63'h0, bubble}, 64'd1);
      fetch_zero_wait(64'h8000_0400, 32'h0080_0413);

      // Reset mid-operation: request accepted, then reset while waiting.
      cyc();
      bus.imem_req_ready = 1'b1;
      #1;
      check_val("mrst_req_addr", bus.imem_req_addr, 64'h8000_0404);
      cyc();
      rst = 1'b1;
      #1;
      check_val("mrst_req_valid", {63'h0, bus.imem_req_valid}, 64'd0);
      check_val("mrst_inst_valid", {63'h0, bus.inst_valid}, 64'd0);
      check_val("mrst_bubble", {63'h0, bubble}, 64'd1);
      cyc();
      #1;
      check_val("mrst_inst_pc", bus.inst_pc, RESET_PC);
      fetch_zero_wait(64'h8000_0000, 32'h0090_0493);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
